freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Gate-window frequency meter. Counts rising edges of an external signal over a fixed number of CLK cycles and reports the count with a valid/ack handshake.
- Reads back slow clocks produced by the divider chain, such as the 1 Hz lift tick, or other external pulse sources. Used for self-test and display of the lift timebase.
- Sits on the 50 MHz CLK domain. The measured input is asynchronous to CLK.

Parameters:
- GATE_CYCLES, 50000000, length of the measurement window in CLK cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 32, width of the edge counter and of the result.

Ports:
- CLK  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous signal whose rising edges are counted.
- start  in  1  single-cycle request for one measurement; honoured only in IDLE.
- cont  in  1  continuous mode; while high, windows run back to back.
- ack  in  1  consumer acknowledge for freq_valid.
- freq_out  out  CNT_W  edge count of the last completed window.
- freq_valid  out  1  freq_out holds an unacknowledged result.
- sat  out  1  the last window's edge count saturated.
- overrun  out  1  a result was overwritten before it was acked.
- busy  out  1  high in GATE and DONE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the synchronizer, gate counter and edge counter are cleared. Reset mid-window discards the window with no partial result.
- Input path:
  - sig_in passes through 2 synchronizer flops s1, s2, plus a history flop s3.
  - edge = s2 & ~s3.
  - A sig_in transition reaches edge 2–3 cycles later.
  - Highs or lows shorter than 2 CLK cycles may be lost; this is not an error.
- States: IDLE, GATE, DONE.
- IDLE:
  - busy = 0.
  - If start or cont is high, go to GATE with gate_cnt = 0 and edge_cnt = 0.
- GATE:
  - Lasts exactly GATE_CYCLES cycles.
  - gate_cnt increments each cycle.
  - edge_cnt increments on each cycle with edge = 1.
  - edge_cnt saturates at all-ones and latches an internal sat_int flag.
  - On the cycle with gate_cnt == GATE_CYCLES-1, that cycle's edge is still counted, then go to DONE.
  - start in GATE is ignored.
  - Deasserting cont in GATE lets the current window finish normally.
- DONE:
  - Lasts one cycle. Registers are updated at the end of the cycle.
  - freq_out <= edge_cnt.
  - sat <= sat_int.
  - freq_valid <= 1.
  - overrun <= 1 if freq_valid was 1 and ack is 0 this cycle; otherwise overrun <= 0.
  - If DONE coincides with ack, the old result is consumed and the new result is valid.
  - Edges arriving in DONE are not counted.
  - Next state is GATE (counters cleared) if cont = 1, else IDLE.
  - In continuous mode the period is therefore GATE_CYCLES+1.
- Handshake:
  - freq_valid clears on a cycle with ack = 1 and freq_valid = 1, except in the DONE case above.
  - ack while freq_valid = 0 has no effect.
  - freq_out, sat and overrun hold until the next DONE or reset.
  - overrun clears only at the next DONE (when not overrunning) or at reset.
- Latency: the result is visible on the cycle after DONE, GATE_CYCLES+1 cycles after leaving IDLE.

Test Plan (GATE_CYCLES = 100, CNT_W = 8 unless noted):
- sig_in square wave with period 10 cycles (5 high, 5 low), steady before start; pulse start → busy high; freq_valid rises 101 cycles after start is sampled; freq_out = 10, sat = 0, overrun = 0.
- sig_in held at 0, one start → freq_out = 0 and freq_valid = 1. Then ack → freq_valid = 0 next cycle, freq_out still 0.
- CNT_W = 3, sig_in period 4 cycles (≈25 edges) → freq_out = 7, sat = 1. A following window at period 20 cycles gives freq_out = 5, sat = 0.
- cont = 1, period-10 signal, ack never asserted → results every 101 cycles; second result sets overrun = 1. Assert ack exactly on the third DONE cycle → overrun = 0 and freq_valid stays 1.
- Assert reset at gate_cnt = 50 → all outputs 0 and state IDLE next cycle; no freq_valid appears without a new start.
- start pulsed again during GATE, and cont dropped mid-window → single result only; busy = 0 after DONE; the extra start is ignored.

Source files
------------

// File: rtl/freq_meter_if.sv
// Control and result handshake bundle for the gate-window frequency meter.
interface freq_meter_if #(
   parameter int unsigned CNT_W = 32
);
   logic             start;
   logic             cont;
   logic             ack;
   logic [CNT_W-1:0] freq_out;
   logic             freq_valid;
   logic             sat;
   logic             overrun;
   logic             busy;

   // Controller / result consumer side
   modport master (
      output start, cont, ack,
      input  freq_out, freq_valid, sat, overrun, busy
   );

   // Meter side
   modport slave (
      input  start, cont, ack,
      output freq_out, freq_valid, sat, overrun, busy
   );
endinterface

// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks and publishes the count with a valid/ack handshake.
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         sig_in,
   freq_meter_if.slave  bus
);

   localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

   logic             s1_q, s2_q, s3_q;
   logic             edge_d;
   state_e           state_q;
   logic [GW-1:0]    gate_cnt_q;
   logic [CNT_W-1:0] edge_cnt_q;
   logic             sat_int_q;
   logic [CNT_W-1:0] freq_out_q;
   logic             freq_valid_q;
   logic             sat_q;
   logic             overrun_q;
   logic             busy_q;

   // Two-flop synchronizer plus history flop for rising-edge detection
   always_ff @(posedge CLK) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign edge_d = s2_q & ~s3_q;

   // Measurement FSM with registered result and handshake outputs
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= StIdle;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         sat_int_q    <= 1'b0;
         freq_out_q   <= '0;
         freq_valid_q <= 1'b0;
         sat_q        <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // Consumer ack; DONE overrides this below when a new result lands
         if (freq_valid_q && bus.ack) begin
            freq_valid_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.start || bus.cont) begin
                  state_q    <= StGate;
                  gate_cnt_q <= '0;
                  edge_cnt_q <= '0;
                  sat_int_q  <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            StGate: begin
               if (edge_d) begin
                  if (&edge_cnt_q) begin
                     // Edge lost at full scale: flag the window as saturated
                     sat_int_q <= 1'b1;
                  end else begin
                     edge_cnt_q <= edge_cnt_q + 1'b1;
                  end
               end
               if (gate_cnt_q == GateLast) begin
                  state_q <= StDone;
               end else begin
                  gate_cnt_q <= gate_cnt_q + 1'b1;
               end
            end

            StDone: begin
               freq_out_q   <= edge_cnt_q;
               sat_q        <= sat_int_q;
               freq_valid_q <= 1'b1;
               overrun_q    <= freq_valid_q & ~bus.ack;
               if (bus.cont) begin
                  state_q    <= StGate;
                  gate_cnt_q <= '0;
                  edge_cnt_q <= '0;
                  sat_int_q  <= 1'b0;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.freq_out   = freq_out_q;
   assign bus.freq_valid = freq_valid_q;
   assign bus.sat        = sat_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: table of single-shot measurements on two instances
// (8-bit and 3-bit counters) plus hand-written continuous/reset sequences.
module tb_freq_meter;

   localparam int unsigned Gate = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sig_a = 1'b0;
   logic sig_b = 1'b0;
   int   per_a = 0;
   int   per_b = 0;

   int n_checks = 0;
   int n_fail   = 0;

   freq_meter_if #(.CNT_W(8)) ifa ();
   freq_meter_if #(.CNT_W(3)) ifb ();

   freq_meter #(.GATE_CYCLES(Gate), .CNT_W(8)) dut_a (
      .CLK    (clk),
      .reset  (rst),
      .sig_in (sig_a),
      .bus    (ifa.slave)
   );

   freq_meter #(.GATE_CYCLES(Gate), .CNT_W(3)) dut_b (
      .CLK    (clk),
      .reset  (rst),
      .sig_in (sig_b),
      .bus    (ifb.slave)
   );

   initial forever #10 clk = ~clk;

   // Square-wave generators: period 0 holds the line low
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         if (per_a == 0) begin
            sig_a = 1'b0;
         end else begin
            ph    = ph % per_a;
            sig_a = (ph < per_a / 2);
            ph    = ph + 1;
         end
      end
   end

   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         if (per_b == 0) begin
            sig_b = 1'b0;
         end else begin
            ph    = ph % per_b;
            sig_b = (ph < per_b / 2);
            ph    = ph + 1;
         end
      end
   end

   // Muxed view of the selected instance's outputs
   int         sel = 0;
   logic [7:0] m_freq;
   logic       m_valid, m_sat, m_ovr, m_busy;

   always_comb begin
      m_freq  = (sel == 0) ? ifa.freq_out : {5'b0, ifb.freq_out};
      m_valid = (sel == 0) ? ifa.freq_valid : ifb.freq_valid;
      m_sat   = (sel == 0) ? ifa.sat : ifb.sat;
      m_ovr   = (sel == 0) ? ifa.overrun : ifb.overrun;
      m_busy  = (sel == 0) ? ifa.busy : ifb.busy;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel == 0) ifa.start = v;
      else ifb.start = v;
   endtask

   task automatic set_ack(input logic v);
      if (sel == 0) ifa.ack = v;
      else ifb.ack = v;
   endtask

   typedef struct {
      string name;
      int    dut;
      int    period;
      int    exp_freq;
      bit    exp_sat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"a_per10", 0, 10, 10, 1'b0};
      vecs[1] = '{"a_low",   0, 0,  0,  1'b0};
      vecs[2] = '{"b_per4",  1, 4,  7,  1'b1};
      vecs[3] = '{"b_per20", 1, 20, 5,  1'b0};
      vecs[4] = '{"a_per25", 0, 25, 4,  1'b0};
      vecs[5] = '{"a_per50", 0, 50, 2,  1'b0};

      ifa.start = 0; ifa.cont = 0; ifa.ack = 0;
      ifb.start = 0; ifb.cont = 0; ifb.ack = 0;

      tick(3);
      rst = 1'b0;
      chk("rst_freq",  ifa.freq_out, 0);
      chk("rst_valid", ifa.freq_valid, 0);
      chk("rst_sat",   ifa.sat, 0);
      chk("rst_ovr",   ifa.overrun, 0);
      chk("rst_busy",  ifa.busy, 0);

      // Single-shot measurements
      foreach (vecs[k]) begin
         sel = vecs[k].dut;
         if (sel == 0) per_a = vecs[k].period;
         else per_b = vecs[k].period;
         tick(30);
         set_start(1'b1);
         tick(1);
         set_start(1'b0);
         chk({vecs[k].name, "_busy"}, m_busy, 1);
         tick(Gate);
         chk({vecs[k].name, "_early"}, m_valid, 0);
         tick(1);
         chk({vecs[k].name, "_valid"}, m_valid, 1);
         chk({vecs[k].name, "_freq"}, m_freq, vecs[k].exp_freq);
         chk({vecs[k].name, "_sat"}, m_sat, vecs[k].exp_sat);
         chk({vecs[k].name, "_ovr"}, m_ovr, 0);
         chk({vecs[k].name, "_idle"}, m_busy, 0);
         set_ack(1'b1);
         tick(1);
         set_ack(1'b0);
         chk({vecs[k].name, "_acked"}, m_valid, 0);
         chk({vecs[k].name, "_hold"}, m_freq, vecs[k].exp_freq);
      end

      // Continuous mode with overrun and ack coinciding with DONE
      sel   = 0;
      per_a = 10;
      tick(30);
      ifa.cont = 1'b1;
      tick(1);
      tick(Gate);
      chk("cont_early", ifa.freq_valid, 0);
      tick(1);
      chk("cont1_valid", ifa.freq_valid, 1);
      chk("cont1_freq",  ifa.freq_out, 10);
      chk("cont1_ovr",   ifa.overrun, 0);
      chk("cont1_busy",  ifa.busy, 1);
      tick(Gate + 1);
      chk("cont2_valid", ifa.freq_valid, 1);
      chk("cont2_ovr",   ifa.overrun, 1);
      chk("cont2_freq",  ifa.freq_out, 10);
      tick(Gate);
      ifa.ack = 1'b1;  // third DONE cycle
      tick(1);
      ifa.ack = 1'b0;
      chk("cont3_ovr",   ifa.overrun, 0);
      chk("cont3_valid", ifa.freq_valid, 1);
      ifa.cont = 1'b0;
      tick(Gate + 1);
      chk("cont4_valid", ifa.freq_valid, 1);
      chk("cont4_ovr",   ifa.overrun, 1);
      chk("cont4_busy",  ifa.busy, 0);
      ifa.ack = 1'b1;
      tick(1);
      ifa.ack = 1'b0;
      chk("cont4_acked", ifa.freq_valid, 0);

      // Reset in the middle of a window
      ifa.start = 1'b1;
      tick(1);
      ifa.start = 1'b0;
      tick(50);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_freq",  ifa.freq_out, 0);
      chk("mid_rst_valid", ifa.freq_valid, 0);
      chk("mid_rst_ovr",   ifa.overrun, 0);
      chk("mid_rst_sat",   ifa.sat, 0);
      chk("mid_rst_busy",  ifa.busy, 0);
      tick(150);
      chk("mid_rst_novalid", ifa.freq_valid, 0);
      chk("mid_rst_nobusy",  ifa.busy, 0);

      // Extra start during GATE and cont dropped mid-window
      ifa.cont = 1'b1;
      tick(1);
      tick(30);
      ifa.start = 1'b1;
      ifa.cont  = 1'b0;
      tick(1);
      ifa.start = 1'b0;
      tick(69);
      chk("drop_early", ifa.freq_valid, 0);
      tick(1);
      chk("drop_valid", ifa.freq_valid, 1);
      chk("drop_freq",  ifa.freq_out, 10);
      chk("drop_ovr",   ifa.overrun, 0);
      chk("drop_busy",  ifa.busy, 0);
      ifa.ack = 1'b1;
      tick(1);
      ifa.ack = 1'b0;
      tick(150);
      chk("drop_single", ifa.freq_valid, 0);
      chk("drop_idle",   ifa.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
